// File: rtl/dlx_shift_issue.sv
// dlx_shift_issue
// Requesting-side issue/writeback controller for the DLX shift unit.
// Decodes SLL/SRL/SRA (R-type) and SLLI/SRLI/SRAI (I-type) from the execute
// stage, drives the shift unit for SH_LATENCY+1 enabled cycles, captures the
// result and hands it to register writeback through a valid/ready handshake.
// Encodings that are not supported shifts produce a one-cycle illegal pulse.
//
// Ports:
//   clk2, rst2            clock (rising edge), async active-high reset
//   in_valid/in_ready     instruction handshake from execute
//   in_instr              32-bit DLX instruction word
//   in_rs1_val            data to shift
//   in_rs2_val            R-type shift amount in bits [4:0]
//   flush                 synchronous abort of the in-flight instruction
//   sh_en/sh_op/sh_amt/sh_in   shift unit request (op: 000 SLL, 010 SRL, 011 SRA)
//   sh_result             shift unit result
//   wb_valid/wb_ready     writeback handshake
//   wb_rd/wb_data         writeback destination and value
//   illegal               pulse: accepted instruction is not a supported shift
module dlx_shift_issue #(
    parameter int unsigned SH_LATENCY = 2
) (
    input  logic        clk2,
    input  logic        rst2,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [31:0] in_instr,
    input  logic [31:0] in_rs1_val,
    input  logic [31:0] in_rs2_val,
    input  logic        flush,
    output logic        sh_en,
    output logic [2:0]  sh_op,
    output logic [4:0]  sh_amt,
    output logic [31:0] sh_in,
    input  logic [31:0] sh_result,
    output logic        wb_valid,
    input  logic        wb_ready,
    output logic [4:0]  wb_rd,
    output logic [31:0] wb_data,
    output logic        illegal
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_EXEC = 2'd1,
        ST_WB   = 2'd2
    } state_t;

    localparam logic [3:0] LAT = 4'(SH_LATENCY);

    localparam logic [2:0] OP_SLL = 3'b000;
    localparam logic [2:0] OP_SRL = 3'b010;
    localparam logic [2:0] OP_SRA = 3'b011;

    state_t      r_state;
    state_t      w_state_nxt;

    logic [3:0]  r_cnt;
    logic [4:0]  r_rd;
    logic [2:0]  r_sh_op;
    logic [4:0]  r_sh_amt;
    logic [31:0] r_sh_in;
    logic        r_in_ready;
    logic        r_sh_en;
    logic        r_wb_valid;
    logic [4:0]  r_wb_rd;
    logic [31:0] r_wb_data;
    logic        r_illegal;

    logic        w_legal;
    logic [2:0]  w_op;
    logic [4:0]  w_amt;
    logic [4:0]  w_rd;
    logic        w_take;
    logic        w_last_exec;
    logic        w_capture;

    // Instruction fields that never influence decode; the name keeps them out of unused-signal reports.
    logic        w_unused;
    assign w_unused = ^{in_rs2_val[31:5], in_instr[25:21], in_instr[10:6]};

    // Combinational decode of the instruction presented by the execute stage.
    always_comb begin
        w_legal = 1'b0;
        w_op    = OP_SLL;
        w_amt   = 5'd0;
        w_rd    = 5'd0;
        case (in_instr[31:26])
            6'h00: begin
                w_rd  = in_instr[15:11];
                w_amt = in_rs2_val[4:0];
                case (in_instr[5:0])
                    6'h04: begin w_legal = 1'b1; w_op = OP_SLL; end
                    6'h06: begin w_legal = 1'b1; w_op = OP_SRL; end
                    6'h07: begin w_legal = 1'b1; w_op = OP_SRA; end
                    default: begin w_legal = 1'b0; w_op = OP_SLL; end
                endcase
            end
            6'h14: begin w_legal = 1'b1; w_op = OP_SLL; w_rd = in_instr[20:16]; w_amt = in_instr[4:0]; end
            6'h16: begin w_legal = 1'b1; w_op = OP_SRL; w_rd = in_instr[20:16]; w_amt = in_instr[4:0]; end
            6'h17: begin w_legal = 1'b1; w_op = OP_SRA; w_rd = in_instr[20:16]; w_amt = in_instr[4:0]; end
            default: begin
                w_legal = 1'b0;
                w_op    = OP_SLL;
            end
        endcase
    end

    // Handshake and end-of-execute qualifiers; flush outranks both accept and capture.
    always_comb begin
        w_take      = in_valid & r_in_ready & ~flush;
        w_last_exec = (r_state == ST_EXEC) && (r_cnt == LAT);
        if (w_last_exec && !flush && (r_rd != 5'd0)) begin
            w_capture = 1'b1;
        end else begin
            w_capture = 1'b0;
        end
    end

    // Next-state logic for the IDLE -> EXEC -> WB sequence.
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_IDLE: begin
                if (w_take && w_legal) begin
                    w_state_nxt = ST_EXEC;
                end else begin
                    w_state_nxt = ST_IDLE;
                end
            end
            ST_EXEC: begin
                if (flush) begin
                    w_state_nxt = ST_IDLE;
                end else if (w_last_exec) begin
                    // r0 is never written, so its result is dropped here.
                    w_state_nxt = (r_rd == 5'd0) ? ST_IDLE : ST_WB;
                end else begin
                    w_state_nxt = ST_EXEC;
                end
            end
            ST_WB: begin
                if (flush || wb_ready) begin
                    w_state_nxt = ST_IDLE;
                end else begin
                    w_state_nxt = ST_WB;
                end
            end
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    // State register.
    always_ff @(posedge clk2 or posedge rst2) begin
        if (rst2) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Handshake outputs registered from the next state so they track the state register exactly.
    always_ff @(posedge clk2 or posedge rst2) begin
        if (rst2) begin
            r_in_ready <= 1'b1;
            r_sh_en    <= 1'b0;
            r_wb_valid <= 1'b0;
            r_illegal  <= 1'b0;
        end else begin
            r_in_ready <= (w_state_nxt == ST_IDLE);
            r_sh_en    <= (w_state_nxt == ST_EXEC);
            r_wb_valid <= (w_state_nxt == ST_WB);
            r_illegal  <= (r_state == ST_IDLE) && w_take && !w_legal;
        end
    end

    // Issue operands, latency counter and writeback payload.
    always_ff @(posedge clk2 or posedge rst2) begin
        if (rst2) begin
            r_cnt     <= 4'd0;
            r_rd      <= 5'd0;
            r_sh_op   <= 3'd0;
            r_sh_amt  <= 5'd0;
            r_sh_in   <= 32'd0;
            r_wb_rd   <= 5'd0;
            r_wb_data <= 32'd0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (w_take && w_legal) begin
                        r_sh_op  <= w_op;
                        r_sh_amt <= w_amt;
                        r_sh_in  <= in_rs1_val;
                        r_rd     <= w_rd;
                        r_cnt    <= 4'd0;
                    end
                end
                ST_EXEC: begin
                    r_cnt <= r_cnt + 4'd1;
                    if (w_capture) begin
                        r_wb_data <= sh_result;
                        r_wb_rd   <= r_rd;
                    end
                end
                default: begin
                    r_cnt <= r_cnt;
                end
            endcase
        end
    end

    assign in_ready = r_in_ready;
    assign sh_en    = r_sh_en;
    assign sh_op    = r_sh_op;
    assign sh_amt   = r_sh_amt;
    assign sh_in    = r_sh_in;
    assign wb_valid = r_wb_valid;
    assign wb_rd    = r_wb_rd;
    assign wb_data  = r_wb_data;
    assign illegal  = r_illegal;

endmodule

// File: tb/tb_dlx_shift_issue.sv
// Self-checking bench for dlx_shift_issue: directed scenarios followed by
// random instructions, checked against a decode/shift reference model.
module tb_dlx_shift_issue;

    localparam int L = 2;

    logic        clk2 = 1'b0;
    logic        rst2;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] in_instr;
    logic [31:0] in_rs1_val;
    logic [31:0] in_rs2_val;
    logic        flush;
    logic        sh_en;
    logic [2:0]  sh_op;
    logic [4:0]  sh_amt;
    logic [31:0] sh_in;
    logic [31:0] sh_result;
    logic        wb_valid;
    logic        wb_ready;
    logic [4:0]  wb_rd;
    logic [31:0] wb_data;
    logic        illegal;

    int vectors = 0;
    int miscompares = 0;
    int en_cnt = 0;

    dlx_shift_issue #(.SH_LATENCY(L)) dut (
        .clk2(clk2), .rst2(rst2), .in_valid(in_valid), .in_ready(in_ready),
        .in_instr(in_instr), .in_rs1_val(in_rs1_val), .in_rs2_val(in_rs2_val),
        .flush(flush), .sh_en(sh_en), .sh_op(sh_op), .sh_amt(sh_amt), .sh_in(sh_in),
        .sh_result(sh_result), .wb_valid(wb_valid), .wb_ready(wb_ready),
        .wb_rd(wb_rd), .wb_data(wb_data), .illegal(illegal)
    );

    always #5 clk2 = ~clk2;

    function automatic logic [31:0] ref_shift(input logic [2:0] op, input logic [4:0] amt, input logic [31:0] x);
        case (op)
            3'b000:  ref_shift = x << amt;
            3'b010:  ref_shift = x >> amt;
            3'b011:  ref_shift = 32'($signed(x) >>> amt);
            default: ref_shift = 32'hBAD0_0BAD;
        endcase
    endfunction

    // Shift unit model: result is only valid once L enabled cycles have elapsed.
    always @(posedge clk2) en_cnt <= sh_en ? en_cnt + 1 : 0;
    always_comb sh_result = (sh_en && en_cnt >= L) ? ref_shift(sh_op, sh_amt, sh_in) : 32'hDEAD_BEEF;

    task automatic ref_decode(input logic [31:0] ins, input logic [31:0] rs2,
                              output bit legal, output logic [2:0] op,
                              output logic [4:0] amt, output logic [4:0] rd);
        logic [5:0] opc;
        logic [5:0] fn;
        opc = ins[31:26];
        fn  = ins[5:0];
        legal = 1'b0; op = 3'b000; amt = 5'd0; rd = 5'd0;
        if (opc == 6'h00 && (fn == 6'h04 || fn == 6'h06 || fn == 6'h07)) begin
            legal = 1'b1;
            op  = (fn == 6'h04) ? 3'b000 : (fn == 6'h06) ? 3'b010 : 3'b011;
            amt = rs2[4:0];
            rd  = ins[15:11];
        end else if (opc == 6'h14 || opc == 6'h16 || opc == 6'h17) begin
            legal = 1'b1;
            op  = (opc == 6'h14) ? 3'b000 : (opc == 6'h16) ? 3'b010 : 3'b011;
            amt = ins[4:0];
            rd  = ins[20:16];
        end
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk2);
        #1;
    endtask

    task automatic run_instr(input logic [31:0] ins, input logic [31:0] rs1,
                             input logic [31:0] rs2, input int stall);
        bit          legal;
        logic [2:0]  op;
        logic [4:0]  amt;
        logic [4:0]  rd;
        logic [31:0] exp;
        int          en_cycles;
        ref_decode(ins, rs2, legal, op, amt, rd);
        exp = ref_shift(op, amt, rs1);
        chk("in_ready_before_accept", in_ready, 1);
        in_valid = 1'b1; in_instr = ins; in_rs1_val = rs1; in_rs2_val = rs2;
        tick();
        in_valid = 1'b0; in_instr = $urandom; in_rs1_val = $urandom; in_rs2_val = $urandom;
        if (!legal) begin
            chk("illegal_pulse", illegal, 1);
            chk("illegal_no_issue", sh_en, 0);
            chk("illegal_in_ready", in_ready, 1);
            return;
        end
        chk("no_illegal_on_legal", illegal, 0);
        en_cycles = 0;
        while (sh_en === 1'b1 && en_cycles < 40) begin
            chk("sh_op", sh_op, op);
            chk("sh_amt", sh_amt, amt);
            chk("sh_in", sh_in, rs1);
            chk("exec_wb_valid_low", wb_valid, 0);
            chk("exec_in_ready_low", in_ready, 0);
            wb_ready = 1'($urandom_range(0, 1));
            en_cycles++;
            tick();
        end
        wb_ready = 1'b0;
        chk("sh_en_cycles", en_cycles, L + 1);
        if (rd == 5'd0) begin
            chk("rd0_no_wb_valid", wb_valid, 0);
            chk("rd0_back_to_idle", in_ready, 1);
            tick();
            chk("rd0_no_wb_valid_later", wb_valid, 0);
            return;
        end
        chk("wb_valid", wb_valid, 1);
        chk("wb_rd", wb_rd, rd);
        chk("wb_data", wb_data, exp);
        chk("wb_in_ready_low", in_ready, 0);
        for (int i = 0; i < stall; i++) begin
            in_valid = 1'b1; in_instr = 32'h5044_0003;
            tick();
            chk("stall_wb_valid", wb_valid, 1);
            chk("stall_wb_rd", wb_rd, rd);
            chk("stall_wb_data", wb_data, exp);
            chk("stall_in_ready", in_ready, 0);
            chk("stall_sh_en", sh_en, 0);
        end
        in_valid = 1'b0;
        wb_ready = 1'b1;
        tick();
        wb_ready = 1'b0;
        chk("wb_done_valid_low", wb_valid, 0);
        chk("wb_done_in_ready", in_ready, 1);
    endtask

    initial begin
        logic [31:0] r;
        logic [31:0] ins;
        logic [4:0]  rdv;
        logic [5:0]  ftab [4];
        logic [5:0]  otab [3];
        ftab[0] = 6'h04; ftab[1] = 6'h06; ftab[2] = 6'h07; ftab[3] = 6'h20;
        otab[0] = 6'h14; otab[1] = 6'h16; otab[2] = 6'h17;

        rst2 = 1'b1; in_valid = 1'b0; in_instr = 32'd0; in_rs1_val = 32'd0;
        in_rs2_val = 32'd0; flush = 1'b0; wb_ready = 1'b0;
        tick(); tick();
        chk("rst_in_ready", in_ready, 1);
        chk("rst_sh_en", sh_en, 0);
        chk("rst_sh_op", sh_op, 0);
        chk("rst_sh_amt", sh_amt, 0);
        chk("rst_sh_in", sh_in, 0);
        chk("rst_wb_valid", wb_valid, 0);
        chk("rst_wb_rd", wb_rd, 0);
        chk("rst_wb_data", wb_data, 0);
        chk("rst_illegal", illegal, 0);
        rst2 = 1'b0;
        tick();

        // SLLI r4,r2,#3
        run_instr(32'h5044_0003, 32'h0000_0011, 32'h0, 0);
        chk("slli_result", wb_data, 32'h0000_0088);
        // SRA r7,r1,r2 with backpressure
        run_instr({6'h00, 5'd1, 5'd2, 5'd7, 5'd0, 6'h07}, 32'hF000_0000, 32'h0000_0024, 5);
        chk("sra_result", wb_data, 32'hFF00_0000);
        // Illegal word immediately followed by a legal one
        run_instr(32'h0000_0020, 32'h1234_5678, 32'h0, 0);
        run_instr({6'h16, 5'd3, 5'd9, 16'h0008}, 32'h8000_0000, 32'h0, 1);

        // flush in second EXEC cycle
        in_valid = 1'b1; in_instr = 32'h5044_0003; in_rs1_val = 32'h1;
        tick();
        in_valid = 1'b0;
        chk("flush_exec1_sh_en", sh_en, 1);
        tick();
        chk("flush_exec2_sh_en", sh_en, 1);
        flush = 1'b1;
        tick();
        flush = 1'b0;
        chk("flush_sh_en_low", sh_en, 0);
        chk("flush_in_ready", in_ready, 1);
        for (int i = 0; i < L + 3; i++) begin
            chk("flush_no_wb_valid", wb_valid, 0);
            tick();
        end

        // flush in WB
        in_valid = 1'b1; in_instr = 32'h5044_0003; in_rs1_val = 32'h2;
        tick();
        in_valid = 1'b0;
        repeat (L + 1) tick();
        chk("flushwb_wb_valid", wb_valid, 1);
        flush = 1'b1;
        tick();
        flush = 1'b0;
        chk("flushwb_wb_valid_low", wb_valid, 0);
        chk("flushwb_in_ready", in_ready, 1);

        // flush together with in_valid in IDLE, legal and illegal
        in_valid = 1'b1; flush = 1'b1; in_instr = 32'h5044_0003;
        tick();
        chk("flush_idle_no_accept", sh_en, 0);
        chk("flush_idle_in_ready", in_ready, 1);
        in_instr = 32'h0000_0020;
        tick();
        in_valid = 1'b0; flush = 1'b0;
        chk("flush_idle_no_illegal", illegal, 0);
        tick();
        chk("flush_idle_still_idle", sh_en, 0);

        // SLLI r0,r1,#1
        run_instr({6'h14, 5'd1, 5'd0, 16'h0001}, 32'h0000_0005, 32'h0, 0);

        // asynchronous reset mid-EXEC
        in_valid = 1'b1; in_instr = {6'h17, 5'd1, 5'd5, 16'h0002}; in_rs1_val = 32'hAAAA_5555;
        tick();
        in_valid = 1'b0;
        chk("prerst_sh_en", sh_en, 1);
        #2 rst2 = 1'b1;
        #1;
        chk("arst_sh_en", sh_en, 0);
        chk("arst_in_ready", in_ready, 1);
        chk("arst_sh_op", sh_op, 0);
        chk("arst_sh_amt", sh_amt, 0);
        chk("arst_sh_in", sh_in, 0);
        chk("arst_wb_valid", wb_valid, 0);
        chk("arst_wb_rd", wb_rd, 0);
        chk("arst_wb_data", wb_data, 0);
        chk("arst_illegal", illegal, 0);
        tick();
        rst2 = 1'b0;
        tick();

        // random instructions
        for (int n = 0; n < 60; n++) begin
            r   = $urandom;
            rdv = ($urandom_range(0, 5) == 0) ? 5'd0 : 5'($urandom_range(1, 31));
            case ($urandom_range(0, 2))
                0:       ins = {6'h00, r[25:16], rdv, r[10:6], ftab[$urandom_range(0, 3)]};
                1:       ins = {otab[$urandom_range(0, 2)], r[25:21], rdv, r[15:0]};
                default: ins = r;
            endcase
            run_instr(ins, $urandom, $urandom, $urandom_range(0, 3));
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
